// File: rtl/demux2_stream_pkg.sv
// Shared constants for the 1:2 stream demultiplexer: word width, select encoding
// and the default per-port FIFO depth.
package demux_pkg;

    localparam int   DATA_W     = 16;
    localparam int   FIFO_DEPTH = 2;
    localparam int   CNT_W      = 8;

    localparam logic SEL_PORT0  = 1'b0;
    localparam logic SEL_PORT1  = 1'b1;

endpackage

// File: rtl/demux2_stream_if.sv
// Bundles the input stream, both output streams and the debug counters of demux2_stream.
interface demux2_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int CNT_WIDTH = CNT_W
);
    logic [WIDTH-1:0]     in_data;
    logic                 in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out0_data;
    logic                 out0_valid;
    logic                 out0_ready;
    logic [WIDTH-1:0]     out1_data;
    logic                 out1_valid;
    logic                 out1_ready;
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;

    // master = producer/consumers around the block, slave = the demux itself
    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

endinterface

// File: rtl/demux2_stream_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head word is shown combinationally
// from storage, so there is never a path from push_data to head_data.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        head_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    // A full FIFO refuses pushes even when popped in the same cycle.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// 1:2 stream demultiplexer: routes each accepted word to one of two buffered
// output ports by its select bit, and counts words delivered per port.
module demux2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    demux2_stream_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 full0, full1;
    logic                 empty0, empty1;
    logic                 push0, push1;
    logic                 pop0, pop1;
    logic                 accept;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    // Readiness looks only at the selected port so one stalled consumer cannot block the other.
    always_comb begin
        bus.in_ready = rst_n && !((bus.in_sel == SEL_PORT1) ? full1 : full0);
        accept       = bus.in_valid && bus.in_ready;
        push0        = accept && (bus.in_sel == SEL_PORT0);
        push1        = accept && (bus.in_sel == SEL_PORT1);
        bus.out0_valid = !empty0;
        bus.out1_valid = !empty1;
        pop0         = bus.out0_valid && bus.out0_ready;
        pop1         = bus.out1_valid && bus.out1_ready;
    end

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (bus.in_data),
        .pop       (pop0),
        .head_data (bus.out0_data),
        .full      (full0),
        .empty     (empty0)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (bus.in_data),
        .pop       (pop1),
        .head_data (bus.out1_data),
        .full      (full1),
        .empty     (empty1)
    );

    // Delivered-word counters wrap freely; they are debug aids, not flow control.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop0) cnt0_d = cnt0_q + CNT_ONE;
        if (pop1) cnt1_d = cnt1_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: a vector table for routing/full/empty cases
// plus hand sequences for reset, streaming, counter wrap and mid-run reset.
module tb_demux2_stream;
    import demux_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux2_stream_if bus ();

    demux2_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        sel;
        logic        v;
        logic        r0;
        logic        r1;
        logic        chk_rdy;
        logic        exp_rdy;
        logic        ev0;
        logic [15:0] ed0;
        logic        ev1;
        logic [15:0] ed1;
        logic [7:0]  ec0;
        logic [7:0]  ec1;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic sel, input logic v,
                         input logic r0, input logic r1);
        bus.in_data    = d;
        bus.in_sel     = sel;
        bus.in_valid   = v;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          n0;
    int          n1;

    initial begin
        total = 0;
        bad   = 0;
        n0    = 0;
        n1    = 0;

        //          d        sel   v     r0    r1    chk   rdy   ev0   ed0       ev1   ed1       c0     c1
        vt[0]  = '{16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 8'd0, 8'd0};
        vt[1]  = '{16'h5678, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5678, 8'd1, 8'd0};
        vt[2]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd1, 8'd1};
        vt[3]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd1, 8'd1};
        vt[4]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd1, 8'd1};
        vt[5]  = '{16'h1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 8'd1, 8'd1};
        vt[6]  = '{16'hABCD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'hABCD, 8'd1, 8'd1};
        vt[7]  = '{16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 8'd2, 8'd2};
        vt[8]  = '{16'h3333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h3333, 1'b0, 16'h0000, 8'd3, 8'd2};
        vt[9]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd4, 8'd2};
        vt[10] = '{16'h9999, 1'bx, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd4, 8'd2};
        vt[11] = '{16'h4444, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4444, 8'd4, 8'd2};
        vt[12] = '{16'h5555, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555, 8'd4, 8'd3};
        vt[13] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd4, 8'd4};

        // Reset held with a valid word offered
        rst_n = 1'b0;
        drive(16'h1234, 1'b0, 1'b1, 1'b1, 1'b1);
        #3;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out0_valid", bus.out0_valid, 1'b0);
        chk("rst_out1_valid", bus.out1_valid, 1'b0);
        chk("rst_out0_data", bus.out0_data, 16'h0000);
        chk("rst_cnt0", bus.cnt0, 8'd0);
        chk("rst_cnt1", bus.cnt1, 8'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_out0_valid", bus.out0_valid, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vt[i].d, vt[i].sel, vt[i].v, vt[i].r0, vt[i].r1);
            #1;
            if (vt[i].chk_rdy) chk($sformatf("v%0d_in_ready", i), bus.in_ready, vt[i].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out0_valid", i), bus.out0_valid, vt[i].ev0);
            if (vt[i].ev0) chk($sformatf("v%0d_out0_data", i), bus.out0_data, vt[i].ed0);
            chk($sformatf("v%0d_out1_valid", i), bus.out1_valid, vt[i].ev1);
            if (vt[i].ev1) chk($sformatf("v%0d_out1_data", i), bus.out1_data, vt[i].ed1);
            chk($sformatf("v%0d_cnt0", i), bus.cnt0, vt[i].ec0);
            chk($sformatf("v%0d_cnt1", i), bus.cnt1, vt[i].ec1);
        end

        // Streaming: 16 back-to-back words alternating ports, both consumers ready
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out0_valid) begin
                if (q0.size() == 0) chk("s_extra0", 1'b1, 1'b0);
                else chk("s_data0", bus.out0_data, q0.pop_front());
                n0++;
            end
            if (bus.out1_valid) begin
                if (q1.size() == 0) chk("s_extra1", 1'b1, 1'b0);
                else chk("s_data1", bus.out1_data, q1.pop_front());
                n1++;
            end
            if (c < 16) drive(16'hA000 + 16'(c), c[0], 1'b1, 1'b1, 1'b1);
            else drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
            #1;
            if (c < 16) begin
                chk("s_in_ready", bus.in_ready, 1'b1);
                if (bus.in_ready) begin
                    if (c[0]) q1.push_back(16'hA000 + 16'(c));
                    else q0.push_back(16'hA000 + 16'(c));
                end
            end
        end
        chk("s_n0", n0, 8);
        chk("s_n1", n1, 8);
        chk("s_cnt0", bus.cnt0, 8'd12);
        chk("s_cnt1", bus.cnt1, 8'd12);

        // 256 words to port 1: its counter comes back around to the same value
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            drive(16'h00FF & 16'(c), 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            if (!bus.in_ready) chk("w_in_ready", bus.in_ready, 1'b1);
        end
        @(negedge clk);
        drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("w_cnt1", bus.cnt1, 8'd12);
        chk("w_cnt0", bus.cnt0, 8'd12);
        chk("w_out1_valid", bus.out1_valid, 1'b0);

        // Reset between edges with two words parked in port 0
        drive(16'hEF01, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("m_out0_valid_pre", bus.out0_valid, 1'b1);
        chk("m_out0_data_pre", bus.out0_data, 16'hEF01);
        chk("m_in_ready_full", bus.in_ready, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("m_out0_valid_rst", bus.out0_valid, 1'b0);
        chk("m_cnt0_rst", bus.cnt0, 8'd0);
        chk("m_cnt1_rst", bus.cnt1, 8'd0);
        chk("m_in_ready_rst", bus.in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("m_out0_valid_post", bus.out0_valid, 1'b0);
        chk("m_out0_data_post", bus.out0_data, 16'h0000);
        @(posedge clk);
        #1;
        chk("m_cnt0_post", bus.cnt0, 8'd0);
        chk("m_out0_valid_post2", bus.out0_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
